// File: rtl/fetch_redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl_if
//   Bundles the handshake and bus signals of the fetch redirect controller.
//   slave  : the controller's view (branch/interrupt inputs, redirect outputs)
//   master : the surrounding pipeline's view (drives requests, observes redirect)
//
//   ex_branch_req / ex_target : taken-branch resolution from Execute
//   intr                      : external interrupt level
//   fetch_next_pc             : PC Fetch would load next
//   int_save_ack              : stack path accepted int_ret_pc
//   branch / branch_addr      : one-cycle redirect strobe and address to Fetch
//   flush_fd / flush_de       : squash Fetch/Decode and Decode/Execute registers
//   int_save_req / int_ret_pc : return-PC save handshake
//   busy                      : controller not idle
// -----------------------------------------------------------------------------
interface fetch_redirect_ctrl_if;
    logic        ex_branch_req;
    logic [15:0] ex_target;
    logic        intr;
    logic [15:0] fetch_next_pc;
    logic        int_save_ack;
    logic        branch;
    logic [15:0] branch_addr;
    logic        flush_fd;
    logic        flush_de;
    logic        int_save_req;
    logic [15:0] int_ret_pc;
    logic        busy;

    modport slave (
        input  ex_branch_req, ex_target, intr, fetch_next_pc, int_save_ack,
        output branch, branch_addr, flush_fd, flush_de, int_save_req,
               int_ret_pc, busy
    );

    modport master (
        output ex_branch_req, ex_target, intr, fetch_next_pc, int_save_ack,
        input  branch, branch_addr, flush_fd, flush_de, int_save_req,
               int_ret_pc, busy
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//   Turns Execute branch resolutions and external interrupts into the
//   one-cycle redirect pulse consumed by Fetch, squashing wrong-path
//   instructions with pipeline flushes. Interrupts first hand the return PC
//   to the stack path (save handshake) and then vector to INT_VECTOR.
//
//   Parameters:
//     INT_VECTOR   : interrupt handler address
//     FLUSH_CYCLES : cycles flush_fd stays high per redirect (1..7)
//   Ports:
//     clk   : clock, posedge active
//     reset : asynchronous, active-high
//     fr    : slave side of fetch_redirect_ctrl_if (see interface header)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter logic [15:0] INT_VECTOR   = 16'd2,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_redirect_ctrl_if.slave   fr
);

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH, INT_SAVE} state_t;

    // FLUSH state covers the flush cycles that follow the REDIRECT cycle.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        intr_q;
    logic        intr_pend_q, intr_pend_d;
    logic        branch_q, branch_d;
    logic        flush_fd_q, flush_fd_d;
    logic        flush_de_q, flush_de_d;
    logic        save_req_q, save_req_d;
    logic        busy_q, busy_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] ret_pc_q, ret_pc_d;
    logic        intr_rise;

    assign intr_rise = fr.intr & ~intr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        branch_d    = 1'b0;
        flush_fd_d  = 1'b0;
        flush_de_d  = 1'b0;
        save_req_d  = 1'b0;
        addr_d      = addr_q;
        ret_pc_d    = ret_pc_q;
        // An edge is captured in every state so one arriving mid-flush is kept.
        intr_pend_d = intr_pend_q | intr_rise;

        case (state_q)
            IDLE: begin
                // Branch wins over a pending interrupt in the same cycle.
                if (fr.ex_branch_req) begin
                    addr_d     = fr.ex_target;
                    state_d    = REDIRECT;
                    branch_d   = 1'b1;
                    flush_fd_d = 1'b1;
                    flush_de_d = 1'b1;
                end else if (intr_pend_q) begin
                    ret_pc_d    = fr.fetch_next_pc;
                    state_d     = INT_SAVE;
                    save_req_d  = 1'b1;
                    flush_fd_d  = 1'b1;
                    flush_de_d  = 1'b1;
                    intr_pend_d = intr_rise;
                end
            end
            REDIRECT: begin
                cnt_d = FLUSH_LOAD;
                if (FLUSH_CYCLES == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d    = FLUSH;
                    flush_fd_d = 1'b1;
                end
            end
            FLUSH: begin
                // Branch requests here come from squashed instructions.
                cnt_d = cnt_q - 3'd1;
                if (cnt_d == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_fd_d = 1'b1;
                end
            end
            INT_SAVE: begin
                // No timeout: the ack is awaited indefinitely.
                if (fr.int_save_ack) begin
                    addr_d     = INT_VECTOR;
                    state_d    = REDIRECT;
                    branch_d   = 1'b1;
                    flush_fd_d = 1'b1;
                    flush_de_d = 1'b1;
                end else begin
                    save_req_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            intr_q      <= 1'b0;
            intr_pend_q <= 1'b0;
            branch_q    <= 1'b0;
            flush_fd_q  <= 1'b0;
            flush_de_q  <= 1'b0;
            save_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= 16'd0;
            ret_pc_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            intr_q      <= fr.intr;
            intr_pend_q <= intr_pend_d;
            branch_q    <= branch_d;
            flush_fd_q  <= flush_fd_d;
            flush_de_q  <= flush_de_d;
            save_req_q  <= save_req_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            ret_pc_q    <= ret_pc_d;
        end
    end

    assign fr.branch       = branch_q;
    assign fr.branch_addr  = addr_q;
    assign fr.flush_fd     = flush_fd_q;
    assign fr.flush_de     = flush_de_q;
    assign fr.int_save_req = save_req_q;
    assign fr.int_ret_pc   = ret_pc_q;
    assign fr.busy         = busy_q;

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Redirect controller sitting upstream of the Fetch stage's `branch`/`branchAdd` inputs. It turns branch resolutions from Execute and external interrupt requests into the one-cycle redirect pulse Fetch consumes, and squashes wrong-path instructions with pipeline flushes. For interrupts it runs a save handshake that hands the return PC to the stack path before vectoring. It is posedge-clocked; its outputs are stable across the following negedge, where Fetch updates PC.

## Interface
- `INT_VECTOR`, 16'd2: interrupt handler address driven on `branch_addr`.
- `FLUSH_CYCLES`, 2: cycles `flush_fd` stays high per redirect; legal range 1..7.
- `clk`  in  1  clock, posedge active.
- `reset`  in  1  asynchronous, active-high.
- `ex_branch_req`  in  1  Execute resolved a taken branch or jump this cycle.
- `ex_target`  in  16  branch target, valid with `ex_branch_req`.
- `intr`  in  1  external interrupt request, level input; only a rising edge is acted on.
- `fetch_next_pc`  in  16  PC Fetch would load next (low 16 bits).
- `int_save_ack`  in  1  stack path accepted `int_ret_pc`.
- `branch`  out  1  redirect strobe to Fetch `branch`.
- `branch_addr`  out  16  redirect address to Fetch `branchAdd`.
- `flush_fd`  out  1  squash the Fetch/Decode register.
- `flush_de`  out  1  squash the Decode/Execute register.
- `int_save_req`  out  1  return-PC save request.
- `int_ret_pc`  out  16  return PC, held while `int_save_req` is high.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- The FSM has four states: IDLE, REDIRECT, FLUSH and INT_SAVE. A 3-bit flush counter and two interrupt flags, `intr_q` and `intr_pend`, complete the state.
- **Interrupt edge detect:** `intr_q` is the registered copy of `intr`. `intr_pend` is set when `intr & ~intr_q`. It is cleared on entering INT_SAVE. A rising edge of `intr` sets `intr_pend` in any state, so an edge arriving mid-flush is not lost.
- **IDLE, branch:** `ex_branch_req` has priority over `intr_pend` in the same cycle.
  - `branch_addr` <= `ex_target`.
  - Go to REDIRECT.
- **IDLE, interrupt:** on `intr_pend` with no branch request:
  - `int_ret_pc` <= `fetch_next_pc`.
  - Go to INT_SAVE.
- **REDIRECT:** lasts exactly one cycle.
  - `branch`=1, `flush_fd`=1, `flush_de`=1.
  - Counter loads `FLUSH_CYCLES`-1.
  - Go to FLUSH, or directly to IDLE if `FLUSH_CYCLES`=1.
- **FLUSH:**
  - `flush_fd`=1; `branch`=0; `flush_de`=0.
  - The counter decrements each cycle; at 0 the FSM goes to IDLE.
  - `ex_branch_req` is ignored here because it comes from a squashed wrong-path instruction.
- **INT_SAVE:**
  - `int_save_req`=1; `int_ret_pc` is held.
  - `flush_fd` and `flush_de` are high in the first INT_SAVE cycle only.
  - `ex_branch_req` is ignored.
  - When `int_save_ack` is sampled high: `branch_addr` <= `INT_VECTOR`; go to REDIRECT.
  - `int_save_req` drops in the REDIRECT cycle.
  - There is no timeout; the block waits for the ack indefinitely.
- **Reset:** asynchronous and immediate. All outputs return to 0, state returns to IDLE, and counter, `intr_q` and `intr_pend` clear. An in-flight save request is abandoned.
- `branch_addr` holds its last value whenever `branch`=0.

## Timing
- All outputs are registered. Redirect latency from a branch request:
  - `ex_branch_req` is sampled at posedge N.
  - `branch` is high from posedge N+1 to N+2.
  - Fetch loads the target at the negedge inside cycle N+1.
- `flush_fd` is high for cycles N+1 .. N+`FLUSH_CYCLES`.
- `busy` is high from N+1 until the return to IDLE.
- Interrupt sequence:
  - Edge seen at posedge E; `intr_pend` is high after E.
  - INT_SAVE is entered at E+1 if the block is IDLE.
  - With the ack sampled at posedge A, `branch`=1 from A+1 to A+2.
- A branch request in the last FLUSH cycle is ignored. A request arriving the cycle after the return to IDLE is served.
- Back-to-back redirects occur at most once every `FLUSH_CYCLES`+1 cycles.

## Test plan
- **Branch, default params:** reset, then `ex_branch_req`=1 with `ex_target`=16'h0040 for 1 cycle.
  - Next cycle: `branch`=1, `branch_addr`=16'h0040, `flush_fd`=`flush_de`=1.
  - Following cycle: `flush_fd` only.
  - Then IDLE with `busy`=0.
- **Squashed branch:** a second `ex_branch_req` during FLUSH with target 16'h0099 gives no redirect, and `branch_addr` stays 16'h0040.
- **Interrupt:** `fetch_next_pc`=16'd57, then `intr` rises.
  - `int_save_req`=1 and `int_ret_pc`=57 appear 2 cycles after the edge.
  - Ack after 3 cycles gives `branch`=1 with `branch_addr`=16'd2.
  - Holding `intr` high afterwards causes no second entry.
- **Branch and interrupt in the same cycle:** the branch redirect happens first. INT_SAVE follows after the flush, capturing the `fetch_next_pc` seen at that point.
- **Reset mid-save:** with `int_save_req`=1, pulse `reset` asynchronously (not on a clock edge). All outputs drop to 0 immediately, and a later ack is ignored.
- **`FLUSH_CYCLES`=1:** the block returns to IDLE directly after REDIRECT, and a branch in the very next cycle is accepted.
